// File: rtl/level_button_conditioner_if.sv
// Level-button bundle between the raw pushbutton pins and the conditioner outputs.
// The slave side is the conditioner; the master side drives btn_raw and observes the results.
interface level_button_conditioner_if #(
   parameter int N_BTN = 4
);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_stable;
   logic [N_BTN-1:0] level_buttons;
   logic [N_BTN-1:0] press_pulse;
   logic             multi_lock;

   modport master (
      output btn_raw,
      input  btn_stable,
      input  level_buttons,
      input  press_pulse,
      input  multi_lock
   );

   modport slave (
      input  btn_raw,
      output btn_stable,
      output level_buttons,
      output press_pulse,
      output multi_lock
   );
endinterface

// File: rtl/level_button_conditioner.sv
// Synchronizes, debounces and one-hot filters the level pushbuttons; press shows up
// DEBOUNCE_CYCLES+2 cycles later on btn_stable, +3 on level_buttons/press_pulse; no backpressure.
module level_button_conditioner #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                       clk,
   input  logic                       reset,
   level_button_conditioner_if.slave  bus
);
   localparam int               POP_W    = $clog2(N_BTN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] sync_meta;
   logic [N_BTN-1:0] sync;
   logic [CNT_W-1:0] cnt [N_BTN];
   logic [N_BTN-1:0] btn_stable;
   logic [N_BTN-1:0] level_buttons;
   logic [N_BTN-1:0] level_next;
   logic [N_BTN-1:0] press_pulse;
   logic             multi_lock;
   logic             lock_next;
   logic [POP_W-1:0] pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= bus.btn_raw;
         sync      <= sync_meta;
      end
   end

   // Any cycle where the synchronized level agrees with the accepted level restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_stable <= '0;
         for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (sync[i] == btn_stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               btn_stable[i] <= sync[i];
               cnt[i]        <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < N_BTN; i++) pop = pop + POP_W'(btn_stable[i]);
   end

   // Lockout set by any chord is only cleared once every button is released.
   always_comb begin
      level_next = '0;
      lock_next  = multi_lock;
      if (pop == '0) begin
         lock_next = 1'b0;
      end else if (pop > POP_W'(1)) begin
         lock_next = 1'b1;
      end else if (!multi_lock) begin
         level_next = btn_stable;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_buttons <= '0;
         press_pulse   <= '0;
         multi_lock    <= 1'b0;
      end else begin
         level_buttons <= level_next;
         press_pulse   <= level_next & ~level_buttons;
         multi_lock    <= lock_next;
      end
   end

   assign bus.btn_stable    = btn_stable;
   assign bus.level_buttons = level_buttons;
   assign bus.press_pulse   = press_pulse;
   assign bus.multi_lock    = multi_lock;
endmodule

// File: tb/tb_level_button_conditioner.sv
// Bench for level_button_conditioner with DEBOUNCE_CYCLES=4; per-cycle vector table plus
// hand-written pulse-latency and asynchronous-reset sequences.
module tb_level_button_conditioner;
   localparam int D     = 4;
   localparam int CNT_W = 3;
   localparam int N     = 4;

   typedef struct {
      int unsigned rep;
      logic        rst;
      logic [N-1:0] raw;
      logic [N-1:0] stable;
      logic [N-1:0] level;
      logic [N-1:0] pulse;
      logic         lock;
   } vec_t;

   typedef struct {
      logic [N-1:0] stable;
      logic [N-1:0] level;
      logic [N-1:0] pulse;
      logic         lock;
      int           cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   vec_t vecs[$];
   exp_t sbq[$];

   level_button_conditioner_if #(.N_BTN(N)) bus ();

   level_button_conditioner #(
      .N_BTN(N),
      .DEBOUNCE_CYCLES(D),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic void add(input int unsigned rep, input logic rst, input logic [N-1:0] raw,
                               input logic [N-1:0] stable, input logic [N-1:0] level,
                               input logic [N-1:0] pulse, input logic lock);
      vec_t v;
      v.rep = rep; v.rst = rst; v.raw = raw;
      v.stable = stable; v.level = level; v.pulse = pulse; v.lock = lock;
      vecs.push_back(v);
   endfunction

   initial begin
      int   c;
      int   found;
      exp_t e;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      bus.btn_raw = '0;

      // Expected values are those visible just before the edge that samples the row's inputs.
      // Test 1: single clean press of bit 1
      add(3,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      add(6,  1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0);
      add(1,  1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0);
      add(1,  1, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 0);
      add(4,  1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 0);
      // Test 2: bounce shorter than the debounce window (reset must clear held outputs at once)
      add(3,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      for (int k = 0; k < 8; k++) begin
         add(3, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
         add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      end
      add(4,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      // Test 3: chord lockout and partial release
      add(2,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      add(6,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
      add(1,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
      add(1,  1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0);
      add(2,  1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0);
      add(6,  1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 0);
      add(1,  1, 4'b0101, 4'b0101, 4'b0001, 4'b0000, 0);
      add(5,  1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1);
      add(6,  1, 4'b0100, 4'b0101, 4'b0000, 4'b0000, 1);
      add(6,  1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1);
      add(6,  1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1);
      add(1,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
      add(3,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      // Test 4: reset pulse mid-debounce discards the partial count
      add(2,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      add(5,  1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0);
      add(1,  0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0);
      add(6,  1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0);
      add(1,  1, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0);
      add(1,  1, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 0);
      add(2,  1, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 0);
      // Test 5: two buttons accepted on the same cycle
      add(2,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      add(6,  1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0);
      add(1,  1, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 0);
      add(4,  1, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 1);
      // Test 6: press held 20 cycles, then release
      add(2,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      add(6,  1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0);
      add(1,  1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0);
      add(1,  1, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 0);
      add(12, 1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 0);
      add(6,  1, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 0);
      add(1,  1, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 0);
      add(4,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

      c = 0;
      foreach (vecs[vi]) begin
         for (int r = 0; r < int'(vecs[vi].rep); r++) begin
            @(negedge clk);
            reset       = vecs[vi].rst;
            bus.btn_raw = vecs[vi].raw;
            e.stable = vecs[vi].stable;
            e.level  = vecs[vi].level;
            e.pulse  = vecs[vi].pulse;
            e.lock   = vecs[vi].lock;
            e.cyc    = vecs[vi].rst ? c : -1;
            sbq.push_back(e);
            if (vecs[vi].rst) c++;
            else c = 0;
            #1;
            e = sbq.pop_front();
            chk("btn_stable",    e.cyc, 32'(bus.btn_stable),    32'(e.stable));
            chk("level_buttons", e.cyc, 32'(bus.level_buttons), 32'(e.level));
            chk("press_pulse",   e.cyc, 32'(bus.press_pulse),   32'(e.pulse));
            chk("multi_lock",    e.cyc, 32'(bus.multi_lock),    32'(e.lock));
         end
      end

      // Bounded wait for the press pulse, then an asynchronous reset away from any edge.
      @(negedge clk);
      reset = 1'b0;
      bus.btn_raw = '0;
      @(negedge clk);
      reset = 1'b1;
      bus.btn_raw = 4'b0001;
      found = -1;
      for (int i = 1; i <= 20 && found < 0; i++) begin
         @(negedge clk);
         #1;
         if (bus.press_pulse == 4'b0001) found = i;
      end
      chk("pulse_latency", found, 32'(found), 32'(D + 3));
      @(negedge clk);
      #1;
      chk("held_level", found + 1, 32'(bus.level_buttons), 32'h1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("async_rst_stable", -1, 32'(bus.btn_stable),    32'h0);
      chk("async_rst_level",  -1, 32'(bus.level_buttons), 32'h0);
      chk("async_rst_pulse",  -1, 32'(bus.press_pulse),   32'h0);
      chk("async_rst_lock",   -1, 32'(bus.multi_lock),    32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
